fp16_add_sequencer: RTL and testbench

Multi-cycle controller for the half-precision (1/5/10) floating-point adder datapath. It accepts an operand pair over a valid/ready handshake, then drives four stages: exponent compare/swap, mantissa alignment, signed mantissa add, and leading-one normalization. It returns the packed result over a second valid/ready handshake. The block sits between the operand source and the result consumer, and it owns all sequencing of the normalization shift (direction and shift count).

---
 rtl/fp16_pkg.sv | 35 +++
 rtl/fp_lead_one_det.sv | 24 ++
 rtl/fp16_add_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_fp16_add_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 add sequencer.
// Holds the FSM state enum, the unpacked operand struct and an unpack helper.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int SUM_W = 12;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_OUT
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unp_t;

    // Exponent 0 flushes the operand to zero; otherwise restore the hidden 1.
    function automatic fp_unp_t unpack(input logic [15:0] x);
        fp_unp_t u;
        u.sign = x[15];
        u.exp  = x[14:10];
        u.man  = (x[14:10] == '0) ? '0 : {1'b1, x[9:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_lead_one_det.sv
// Leading-one detector for the 12-bit adder sum.
// Ports: sum in; dir_right (carry out, shift right by 1), n (left shift count), zero out.
module fp_lead_one_det
    import fp16_pkg::*;
(
    input  logic [SUM_W-1:0] sum,
    output logic             dir_right,
    output logic [3:0]       n,
    output logic             zero
);

    always_comb begin
        dir_right = sum[SUM_W-1];
        zero      = (sum == '0);
        n         = 4'd0;
        // Ascending scan: the highest set bit wins.
        if (!sum[SUM_W-1]) begin
            for (int i = 0; i <= 10; i++) begin
                if (sum[i]) n = 4'(10 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_add_sequencer.sv
// Multi-cycle fp16 adder: ALIGN, ADD, NORM, OUT between two valid/ready handshakes.
// Ports: clk73/rst_n73, in_valid73/in_ready73/a73/b73, out_valid73/out_ready73/result73/zero73/ovf73.
// Build option FP16_SPECIAL_EN: Inf/NaN propagation and saturation to signed Inf.
module fp16_add_sequencer
    import fp16_pkg::*;
(
    input  logic        clk73,
    input  logic        rst_n73,
    input  logic        in_valid73,
    output logic        in_ready73,
    input  logic [15:0] a73,
    input  logic [15:0] b73,
    output logic        out_valid73,
    input  logic        out_ready73,
    output logic [15:0] result73,
    output logic        zero73,
    output logic        ovf73
);

    state_t           state_q, state_d;
    logic [15:0]      a_q, a_d, b_q, b_d;
    logic [MAN_W:0]   ml_q, ml_d, ms_q, ms_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sl_q, sl_d, ss_q, ss_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [15:0]      res_q, res_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef FP16_SPECIAL_EN
    logic             spec_q, spec_d;
    logic [15:0]      spec_res_q, spec_res_d;
`endif

    fp_unp_t          ua, ub, ul, us;
    logic             a_big;
    logic [EXP_W-1:0] dif;

    always_comb begin
        ua    = unpack(a_q);
        ub    = unpack(b_q);
        a_big = {ua.exp, ua.man} >= {ub.exp, ub.man};
        ul    = a_big ? ua : ub;
        us    = a_big ? ub : ua;
        dif   = ul.exp - us.exp;
    end

    logic       lod_right, lod_zero;
    logic [3:0] lod_n;

    fp_lead_one_det u_lod (
        .sum       (sum_q),
        .dir_right (lod_right),
        .n         (lod_n),
        .zero      (lod_zero)
    );

    logic signed [6:0] e_n;
    logic [MAN_W-1:0]  man_n;
    logic              n_flush, n_ovf;
    logic [15:0]       n_res;
    logic              n_zero, n_ovf_o;

    always_comb begin
        if (lod_right) begin
            e_n   = $signed({2'b00, exp_q}) + 7'sd1;
            man_n = sum_q[10:1];
        end else begin
            e_n   = $signed({2'b00, exp_q}) - $signed({3'b000, lod_n});
            man_n = 10'(sum_q << lod_n);
        end
        n_flush = lod_zero || (e_n < 7'sd1);
        n_ovf   = !n_flush && (e_n >= 7'sd31);
        // Exponent wraps modulo 32 unless the special build saturates it.
        n_res   = n_flush ? 16'h0000 : {sl_q, e_n[4:0], man_n};
        n_zero  = n_flush;
        n_ovf_o = n_ovf;
`ifdef FP16_SPECIAL_EN
        if (spec_q) begin
            n_res   = spec_res_q;
            n_zero  = 1'b0;
            n_ovf_o = 1'b0;
        end else if (n_ovf) begin
            n_res = {sl_q, PINF[14:0]};
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        ml_d        = ml_q;
        ms_d        = ms_q;
        exp_d       = exp_q;
        sl_d        = sl_q;
        ss_d        = ss_q;
        sum_d       = sum_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef FP16_SPECIAL_EN
        spec_d      = spec_q;
        spec_res_d  = spec_res_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid73) begin
                    a_d        = a73;
                    b_d        = b73;
                    in_ready_d = 1'b0;
                    state_d    = S_ALIGN;
                end
            end
            S_ALIGN: begin
                ml_d    = ul.man;
                ms_d    = (dif > 5'd11) ? '0 : (us.man >> dif);
                exp_d   = ul.exp;
                sl_d    = ul.sign;
                ss_d    = us.sign;
                state_d = S_ADD;
`ifdef FP16_SPECIAL_EN
                spec_d = (a_q[14:10] == 5'h1F) || (b_q[14:10] == 5'h1F);
                if (((a_q[14:10] == 5'h1F) && (a_q[9:0] != '0)) ||
                    ((b_q[14:10] == 5'h1F) && (b_q[9:0] != '0)) ||
                    ((a_q[14:10] == 5'h1F) && (b_q[14:10] == 5'h1F) &&
                     (a_q[15] != b_q[15])))
                    spec_res_d = QNAN;
                else if (a_q[14:10] == 5'h1F)
                    spec_res_d = {a_q[15], PINF[14:0]};
                else
                    spec_res_d = {b_q[15], PINF[14:0]};
`endif
            end
            S_ADD: begin
                // L has the larger magnitude, so the difference never goes negative.
                sum_d   = (sl_q == ss_q) ? ({1'b0, ml_q} + {1'b0, ms_q})
                                         : ({1'b0, ml_q} - {1'b0, ms_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                res_d       = n_res;
                zero_d      = n_zero;
                ovf_d       = n_ovf_o;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready73) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk73 or negedge rst_n73) begin
        if (!rst_n73) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ml_q        <= '0;
            ms_q        <= '0;
            exp_q       <= '0;
            sl_q        <= 1'b0;
            ss_q        <= 1'b0;
            sum_q       <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FP16_SPECIAL_EN
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ml_q        <= ml_d;
            ms_q        <= ms_d;
            exp_q       <= exp_d;
            sl_q        <= sl_d;
            ss_q        <= ss_d;
            sum_q       <= sum_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef FP16_SPECIAL_EN
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
`endif
        end
    end

    assign in_ready73  = in_ready_q;
    assign out_valid73 = out_valid_q;
    assign result73    = res_q;
    assign zero73      = zero_q;
    assign ovf73       = ovf_q;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// Self-checking bench for fp16_add_sequencer.
// Directed cases, backpressure, mid-operation reset and a randomized model comparison.
module tb_fp16_add_sequencer;

    logic        clk73;
    logic        rst_n73;
    logic        in_valid73;
    logic        in_ready73;
    logic [15:0] a73;
    logic [15:0] b73;
    logic        out_valid73;
    logic        out_ready73;
    logic [15:0] result73;
    logic        zero73;
    logic        ovf73;

    int pass_cnt;
    int total_cnt;

    fp16_add_sequencer dut (
        .clk73       (clk73),
        .rst_n73     (rst_n73),
        .in_valid73  (in_valid73),
        .in_ready73  (in_ready73),
        .a73         (a73),
        .b73         (b73),
        .out_valid73 (out_valid73),
        .out_ready73 (out_ready73),
        .result73    (result73),
        .zero73      (zero73),
        .ovf73       (ovf73)
    );

    initial clk73 = 1'b0;
    always #5 clk73 = ~clk73;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Arithmetic reference: real-valued alignment/normalisation on integers.
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic z,
                                  output logic o);
        int ex, ey, mx, my, el, es, ml, ms, sl, ss, d, sum, p, e, man;
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
        my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
        if (ex * 4096 + mx >= ey * 4096 + my) begin
            el = ex; ml = mx; sl = int'(x[15]);
            es = ey; ms = my; ss = int'(y[15]);
        end else begin
            el = ey; ml = my; sl = int'(y[15]);
            es = ex; ms = mx; ss = int'(x[15]);
        end
        d = el - es;
        ms = (d > 11) ? 0 : ms / (1 << d);
        sum = (sl == ss) ? ml + ms : ml - ms;
        r = 16'h0000;
        z = 1'b0;
        o = 1'b0;
        if (sum == 0) begin
            z = 1'b1;
        end else begin
            p = 0;
            while ((sum >> (p + 1)) != 0) p++;
            e = el + p - 10;
            if (p >= 10) man = (sum >> (p - 10)) % 1024;
            else man = (sum << (10 - p)) % 1024;
            if (e < 1) begin
                z = 1'b1;
            end else begin
                o = (e >= 31);
                r = {1'(sl), 5'(e % 32), 10'(man)};
`ifdef FP16_SPECIAL_EN
                if (o) r = (sl != 0) ? 16'hFC00 : 16'h7C00;
`endif
            end
        end
`ifdef FP16_SPECIAL_EN
        if (ex == 31 || ey == 31) begin
            z = 1'b0;
            o = 1'b0;
            if ((ex == 31 && x[9:0] != 0) || (ey == 31 && y[9:0] != 0) ||
                (ex == 31 && ey == 31 && x[15] != y[15]))
                r = 16'h7E00;
            else if (ex == 31)
                r = {x[15], 15'h7C00};
            else
                r = {y[15], 15'h7C00};
        end
`endif
    endfunction

    // Presents one operand pair and waits for out_valid73; lat counts edges
    // from the accepting edge (1) to the edge after which out_valid73 is seen.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         input logic rdy, output logic [15:0] r,
                         output logic z, output logic o, output int lat);
        int w;
        a73 = x;
        b73 = y;
        in_valid73 = 1'b1;
        out_ready73 = rdy;
        w = 0;
        while (!in_ready73 && w < 20) begin
            @(posedge clk73); #1;
            w++;
        end
        @(posedge clk73); #1;
        in_valid73 = 1'b0;
        lat = 1;
        while (!out_valid73 && lat < 50) begin
            @(posedge clk73); #1;
            lat++;
        end
        r = result73;
        z = zero73;
        o = ovf73;
    endtask

    task automatic finish_op();
        out_ready73 = 1'b1;
        @(posedge clk73); #1;
        out_ready73 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n73 = 1'b0;
        in_valid73 = 1'b0;
        out_ready73 = 1'b0;
        a73 = '0;
        b73 = '0;
        repeat (3) @(posedge clk73);
        #1;
        total_cnt++;
        if ({in_ready73, out_valid73, result73, zero73, ovf73} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h z=%b o=%b, want 1 0 0000 0 0",
                     in_ready73, out_valid73, result73, zero73, ovf73);
        else pass_cnt++;
        #4;
        rst_n73 = 1'b1;
        @(posedge clk73); #1;
        total_cnt++;
        if (in_ready73 !== 1'b1)
            $display("FAIL reset_release_ready: got %b want 1", in_ready73);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] r;
        logic z, o;
        int lat;
        do_op(16'h3C00, 16'h3C00, 1'b1, r, z, o, lat);
        total_cnt++;
        if (r !== 16'h4000) $display("FAIL basic_result: got %h want 4000", r);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat);
        else pass_cnt++;
        total_cnt++;
        if (in_ready73 !== 1'b0) $display("FAIL basic_ready_in_out: got %b want 0", in_ready73);
        else pass_cnt++;
        @(posedge clk73); #1;
        out_ready73 = 1'b0;
        total_cnt++;
        if ({in_ready73, out_valid73} !== 2'b10)
            $display("FAIL basic_ready_cycle5: got rdy=%b vld=%b want 1 0", in_ready73, out_valid73);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [15:0] ta [6];
        logic [15:0] tb [6];
        logic [15:0] tr [6];
        logic        tz [6];
        logic        tov [6];
        logic [15:0] r;
        logic z, o;
        int lat;
        ta[0] = 16'h3E00; tb[0] = 16'hBC00; tr[0] = 16'h3800; tz[0] = 1'b0; tov[0] = 1'b0;
        ta[1] = 16'h3C00; tb[1] = 16'hBC00; tr[1] = 16'h0000; tz[1] = 1'b1; tov[1] = 1'b0;
        ta[2] = 16'h3C00; tb[2] = 16'h0C00; tr[2] = 16'h3C00; tz[2] = 1'b0; tov[2] = 1'b0;
        ta[3] = 16'h0000; tb[3] = 16'hC500; tr[3] = 16'hC500; tz[3] = 1'b0; tov[3] = 1'b0;
        ta[4] = 16'hC500; tb[4] = 16'h4500; tr[4] = 16'h0000; tz[4] = 1'b1; tov[4] = 1'b0;
`ifdef FP16_SPECIAL_EN
        ta[5] = 16'h7BFF; tb[5] = 16'h7BFF; tr[5] = 16'h7C00; tz[5] = 1'b0; tov[5] = 1'b1;
`else
        ta[5] = 16'h7BFF; tb[5] = 16'h7BFF; tr[5] = 16'h7FFF; tz[5] = 1'b0; tov[5] = 1'b1;
`endif
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], 1'b1, r, z, o, lat);
            total_cnt++;
            if ({r, z, o} !== {tr[i], tz[i], tov[i]})
                $display("FAIL directed_%0d (%h+%h): got res=%h z=%b o=%b want res=%h z=%b o=%b",
                         i, ta[i], tb[i], r, z, o, tr[i], tz[i], tov[i]);
            else pass_cnt++;
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        a73 = 16'h3C00;
        b73 = 16'h4000;
        in_valid73 = 1'b1;
        out_ready73 = 1'b0;
        @(posedge clk73); #1;
        a73 = 16'h4400;
        b73 = 16'h3C00;
        lat = 1;
        while (!out_valid73 && lat < 50) begin
            @(posedge clk73); #1;
            lat++;
        end
        total_cnt++;
        if (lat !== 4) $display("FAIL bp_latency: got %0d want 4", lat);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk73); #1;
            total_cnt++;
            if ({result73, in_ready73, out_valid73} !== {16'h4200, 1'b0, 1'b1})
                $display("FAIL bp_hold_%0d: got res=%h rdy=%b vld=%b want 4200 0 1",
                         i, result73, in_ready73, out_valid73);
            else pass_cnt++;
        end
        out_ready73 = 1'b1;
        @(posedge clk73); #1;
        out_ready73 = 1'b0;
        total_cnt++;
        if ({in_ready73, out_valid73} !== 2'b10)
            $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready73, out_valid73);
        else pass_cnt++;
        @(posedge clk73); #1;
        in_valid73 = 1'b0;
        total_cnt++;
        if (in_ready73 !== 1'b0) $display("FAIL bp_next_accept: got rdy=%b want 0", in_ready73);
        else pass_cnt++;
        lat = 1;
        while (!out_valid73 && lat < 50) begin
            @(posedge clk73); #1;
            lat++;
        end
        total_cnt++;
        if ({result73, 6'(lat)} !== {16'h4500, 6'd4})
            $display("FAIL bp_second: got res=%h lat=%0d want 4500 lat 4", result73, lat);
        else pass_cnt++;
        finish_op();
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic z, o;
        int lat;
        a73 = 16'h4400;
        b73 = 16'h4400;
        in_valid73 = 1'b1;
        @(posedge clk73); #1;
        in_valid73 = 1'b0;
        @(posedge clk73); #1;
        rst_n73 = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid73, result73, in_ready73, zero73, ovf73} !== {1'b0, 16'h0000, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_mid: got vld=%b res=%h rdy=%b z=%b o=%b want 0 0000 1 0 0",
                     out_valid73, result73, in_ready73, zero73, ovf73);
        else pass_cnt++;
        #2;
        rst_n73 = 1'b1;
        @(posedge clk73); #1;
        do_op(16'h3C00, 16'h3C00, 1'b1, r, z, o, lat);
        total_cnt++;
        if ({r, 6'(lat)} !== {16'h4000, 6'd4})
            $display("FAIL reset_mid_fresh: got res=%h lat=%0d want 4000 lat 4", r, lat);
        else pass_cnt++;
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [15:0] x, y, r, er;
        logic z, o, ez, eo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            model(x, y, er, ez, eo);
            total_cnt++;
            if (in_ready73 !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready73);
            else pass_cnt++;
            do_op(x, y, 1'b1, r, z, o, lat);
            total_cnt++;
            if ({r, z, o, 6'(lat)} !== {er, ez, eo, 6'd4})
                $display("FAIL b2b_%0d (%h+%h): got res=%h z=%b o=%b lat=%0d want %h %b %b 4",
                         i, x, y, r, z, o, lat, er, ez, eo);
            else pass_cnt++;
            @(posedge clk73); #1;
        end
        out_ready73 = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] x, y, r, er;
        logic z, o, ez, eo;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            case (i % 4)
                1: y = {~x[15], x[14:10], 10'($urandom)};
                2: y = {y[15], x[14:10] - 5'($urandom_range(0, 3)), y[9:0]};
                default: ;
            endcase
            model(x, y, er, ez, eo);
            do_op(x, y, 1'($urandom), r, z, o, lat);
            total_cnt++;
            if (r !== er) $display("FAIL rand_result_%0d (%h+%h): got %h want %h", i, x, y, r, er);
            else pass_cnt++;
            total_cnt++;
            if ({z, o} !== {ez, eo})
                $display("FAIL rand_flags_%0d (%h+%h): got z=%b o=%b want z=%b o=%b",
                         i, x, y, z, o, ez, eo);
            else pass_cnt++;
            total_cnt++;
            if (lat !== 4) $display("FAIL rand_latency_%0d: got %0d want 4", i, lat);
            else pass_cnt++;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk73); #1;
            end
            finish_op();
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
